multicycle_control: RTL and testbench

Multi-cycle control unit for the MIPS CPU. It is the successor to the single-cycle decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and stalls on variable-latency instruction and data memories through a req/ready handshake. A parametrised watchdog aborts hung memory accesses. The block drives the NPC, instruction register, RF, ALU, EXT mux and DataMem enables of the datapath.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/inst_decoder.sv | 53 +++++
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multi-cycle control path: opcodes, functs, datapath selects,
// FSM states and decoded instruction classes.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2A;

  localparam int unsigned AluAdd = 0;
  localparam int unsigned AluSub = 1;
  localparam int unsigned AluAnd = 2;
  localparam int unsigned AluOr  = 3;
  localparam int unsigned AluSlt = 4;
  localparam int unsigned AluLui = 5;

  localparam logic [1:0] NpcPc4    = 2'd0;
  localparam logic [1:0] NpcBranch = 2'd1;
  localparam logic [1:0] NpcJump   = 2'd2;
  localparam logic [1:0] NpcReg    = 2'd3;

  localparam logic [1:0] DstRt = 2'd0;
  localparam logic [1:0] DstRd = 2'd1;
  localparam logic [1:0] DstRa = 2'd2;

  localparam logic [1:0] WdAlu = 2'd0;
  localparam logic [1:0] WdMem = 2'd1;
  localparam logic [1:0] WdPc4 = 2'd2;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExec, StAluWb, StMaddr, StMrd, StMwb, StMwr, StBranch, StJump
  } state_e;

  typedef enum logic [3:0] {
    ClsIllegal, ClsRAlu, ClsIAlu, ClsLw, ClsSw, ClsBeq, ClsJ, ClsJal, ClsJr
  } inst_class_e;

endpackage

// File: rtl/inst_decoder.sv
// Combinational opcode/funct decode into an instruction class and the ALU-side controls.
module inst_decoder
  import mips_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3
) (
  input  logic [31:0]        inst,
  output inst_class_e        cls,
  output logic [ALUOP_W-1:0] aluop,
  output logic               extop,
  output logic               alusrc
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = inst[31:26];
  assign funct         = inst[5:0];
  assign unused_fields = ^inst[25:6];

  always_comb begin
    cls    = ClsIllegal;
    aluop  = '0;
    extop  = 1'b0;
    alusrc = 1'b0;
    case (op)
      OpRtype: begin
        case (funct)
          FnAddu: begin cls = ClsRAlu; aluop = ALUOP_W'(AluAdd); end
          FnSubu: begin cls = ClsRAlu; aluop = ALUOP_W'(AluSub); end
          FnAnd:  begin cls = ClsRAlu; aluop = ALUOP_W'(AluAnd); end
          FnOr:   begin cls = ClsRAlu; aluop = ALUOP_W'(AluOr);  end
          FnSlt:  begin cls = ClsRAlu; aluop = ALUOP_W'(AluSlt); end
          FnJr:   cls = ClsJr;
          default: ;
        endcase
      end
      OpAddiu: begin
        cls = ClsIAlu; aluop = ALUOP_W'(AluAdd); extop = 1'b1; alusrc = 1'b1;
      end
      OpOri: begin cls = ClsIAlu; aluop = ALUOP_W'(AluOr);  alusrc = 1'b1; end
      OpLui: begin cls = ClsIAlu; aluop = ALUOP_W'(AluLui); alusrc = 1'b1; end
      OpLw:  begin cls = ClsLw; aluop = ALUOP_W'(AluAdd); extop = 1'b1; alusrc = 1'b1; end
      OpSw:  begin cls = ClsSw; aluop = ALUOP_W'(AluAdd); extop = 1'b1; alusrc = 1'b1; end
      OpBeq: begin cls = ClsBeq; aluop = ALUOP_W'(AluSub); end
      OpJ:   cls = ClsJ;
      OpJal: cls = ClsJal;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with req/ready memory stalls and a watchdog that aborts
// memory accesses stuck for TIMEOUT cycles.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        inst,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic [1:0]         NPCOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrc,
  output logic               EXTOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         WDSel,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               inst_done,
  output logic               illegal,
  output logic               bus_err
);

  // A zero TIMEOUT still needs a legal (1-bit) counter even though it never counts.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  inst_class_e        cls;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_extop;
  logic               dec_alusrc;
  logic               waiting;
  logic               ready;
  logic               timeout;

  inst_decoder #(
    .ALUOP_W (ALUOP_W)
  ) u_dec (
    .inst   (inst),
    .cls    (cls),
    .aluop  (dec_aluop),
    .extop  (dec_extop),
    .alusrc (dec_alusrc)
  );

  // Timeout only fires when ready is absent, so a ready in the limit cycle still completes.
  always_comb begin
    waiting = (state_q == StFetch) || (state_q == StMrd) || (state_q == StMwr);
    ready   = (state_q == StFetch) ? imem_ready : dmem_ready;
    timeout = (TIMEOUT != 0) && waiting && !ready && (cnt_q == CntW'(TIMEOUT));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (imem_ready) state_d = StDecode;
      StDecode: begin
        case (cls)
          ClsRAlu, ClsIAlu:   state_d = StExec;
          ClsLw, ClsSw:       state_d = StMaddr;
          ClsBeq:             state_d = StBranch;
          ClsJ, ClsJal, ClsJr: state_d = StJump;
          default:            state_d = StFetch;
        endcase
      end
      StExec:   state_d = StAluWb;
      StMaddr:  state_d = (cls == ClsLw) ? StMrd : StMwr;
      StMrd:    if (dmem_ready) state_d = StMwb;
      StMwr:    if (dmem_ready) state_d = StFetch;
      default:  state_d = StFetch;
    endcase
    if (timeout) state_d = StFetch;

    if ((state_d != state_q) || timeout) begin
      cnt_d = '0;
    end else if (waiting && (TIMEOUT != 0)) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by rst_n so everything, including imem_req, is quiet during reset.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    NPCOp     = NpcPc4;
    ALUOp     = '0;
    ALUSrc    = 1'b0;
    EXTOp     = 1'b0;
    RegDst    = DstRt;
    WDSel     = WdAlu;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    inst_done = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
          PCWrite  = imem_ready;
        end
        StDecode: illegal = (cls == ClsIllegal);
        StExec: begin
          ALUOp  = dec_aluop;
          ALUSrc = dec_alusrc;
          EXTOp  = dec_extop;
        end
        StAluWb: begin
          RegWrite  = 1'b1;
          RegDst    = (cls == ClsRAlu) ? DstRd : DstRt;
          inst_done = 1'b1;
        end
        StMaddr: begin
          ALUOp  = ALUOP_W'(AluAdd);
          ALUSrc = 1'b1;
          EXTOp  = 1'b1;
        end
        StMrd: dmem_req = 1'b1;
        StMwb: begin
          RegWrite  = 1'b1;
          WDSel     = WdMem;
          inst_done = 1'b1;
        end
        StMwr: begin
          dmem_req  = 1'b1;
          MemWrite  = !timeout;
          inst_done = dmem_ready;
        end
        StBranch: begin
          ALUOp     = ALUOP_W'(AluSub);
          NPCOp     = NpcBranch;
          PCWrite   = zero;
          inst_done = 1'b1;
        end
        StJump: begin
          PCWrite   = 1'b1;
          NPCOp     = (cls == ClsJr) ? NpcReg : NpcJump;
          inst_done = 1'b1;
          if (cls == ClsJal) begin
            RegWrite = 1'b1;
            RegDst   = DstRa;
            WDSel    = WdPc4;
          end
        end
        default: ;
      endcase
      bus_err = timeout;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed cycle-by-cycle bench for multicycle_control with TIMEOUT=4 and hand-computed controls.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        zero, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, PCWrite, IRWrite, ALUSrc, EXTOp, RegWrite, MemWrite;
  logic        inst_done, illegal, bus_err;
  logic [1:0]  NPCOp, RegDst, WDSel;
  logic [2:0]  ALUOp;
  logic [19:0] ctl;

  int total = 0;
  int bad   = 0;

  multicycle_control #(
    .TIMEOUT (4),
    .ALUOP_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .NPCOp      (NPCOp),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .EXTOp      (EXTOp),
    .RegDst     (RegDst),
    .WDSel      (WDSel),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .inst_done  (inst_done),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  assign ctl = {imem_req, dmem_req, PCWrite, IRWrite, NPCOp, ALUOp, ALUSrc, EXTOp,
                RegDst, WDSel, RegWrite, MemWrite, inst_done, illegal, bus_err};

  // Packs named control fields in the same order as ctl.
  function automatic logic [19:0] f(input logic ireq, input logic dreq, input logic pcw,
                                    input logic irw, input logic [1:0] npc,
                                    input logic [2:0] alu, input logic src, input logic ext,
                                    input logic [1:0] dst, input logic [1:0] wd,
                                    input logic rw, input logic mw, input logic done,
                                    input logic ill, input logic berr);
    return {ireq, dreq, pcw, irw, npc, alu, src, ext, dst, wd, rw, mw, done, ill, berr};
  endfunction

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step(input logic [31:0] i, input logic z, input logic ir, input logic dr);
    @(negedge clk);
    inst       = i;
    zero       = z;
    imem_ready = ir;
    dmem_ready = dr;
    #1;
  endtask

  logic [19:0] v_fetch, v_wait, v_none;
  logic [31:0] a_ins [8];
  logic [2:0]  a_op  [8];
  logic        a_src [8];
  logic        a_ext [8];
  logic [1:0]  a_dst [8];
  logic [31:0] j_ins [3];
  logic [19:0] j_exp [3];

  localparam logic [31:0] LwI  = 32'h8C22_0004;
  localparam logic [31:0] SwI  = 32'hAC22_0004;
  localparam logic [31:0] BeqI = 32'h1022_0003;

  initial begin
    rst_n = 1'b0; inst = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    v_fetch = f(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_wait  = f(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_none  = '0;

    a_ins[0] = 32'h0022_1821; a_op[0] = 0; a_src[0] = 0; a_ext[0] = 0; a_dst[0] = 1; // addu
    a_ins[1] = 32'h0022_1823; a_op[1] = 1; a_src[1] = 0; a_ext[1] = 0; a_dst[1] = 1; // subu
    a_ins[2] = 32'h0022_1824; a_op[2] = 2; a_src[2] = 0; a_ext[2] = 0; a_dst[2] = 1; // and
    a_ins[3] = 32'h0022_1825; a_op[3] = 3; a_src[3] = 0; a_ext[3] = 0; a_dst[3] = 1; // or
    a_ins[4] = 32'h0022_182A; a_op[4] = 4; a_src[4] = 0; a_ext[4] = 0; a_dst[4] = 1; // slt
    a_ins[5] = 32'h2422_0005; a_op[5] = 0; a_src[5] = 1; a_ext[5] = 1; a_dst[5] = 0; // addiu
    a_ins[6] = 32'h3422_000F; a_op[6] = 3; a_src[6] = 1; a_ext[6] = 0; a_dst[6] = 0; // ori
    a_ins[7] = 32'h3C02_1234; a_op[7] = 5; a_src[7] = 1; a_ext[7] = 0; a_dst[7] = 0; // lui

    j_ins[0] = 32'h0800_0010; j_exp[0] = f(0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // j
    j_ins[1] = 32'h0C00_0010; j_exp[1] = f(0, 0, 1, 0, 2, 0, 0, 0, 2, 2, 1, 0, 1, 0, 0); // jal
    j_ins[2] = 32'h03E0_0008; j_exp[2] = f(0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // jr

    // Reset: everything quiet, even with ready asserted.
    repeat (2) @(negedge clk);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #1 chk("reset_quiet", ctl, v_none);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1 chk("post_reset_req", ctl, v_wait);

    // ALU instructions: 4 cycles each; dmem_ready held high to show it is ignored.
    for (int i = 0; i < 8; i++) begin
      step(a_ins[i], 0, 1, 1); chk("alu_fetch", ctl, v_fetch);
      step(a_ins[i], 0, 0, 1); chk("alu_decode", ctl, v_none);
      step(a_ins[i], 0, 0, 1);
      chk("alu_exec", ctl, f(0, 0, 0, 0, 0, a_op[i], a_src[i], a_ext[i], 0, 0, 0, 0, 0, 0, 0));
      step(a_ins[i], 0, 0, 1);
      chk("alu_wb", ctl, f(0, 0, 0, 0, 0, 0, 0, 0, a_dst[i], 0, 1, 0, 1, 0, 0));
    end

    // lw with three dmem wait cycles: 8 cycles total.
    step(LwI, 0, 1, 0); chk("lw_fetch", ctl, v_fetch);
    step(LwI, 0, 0, 0); chk("lw_decode", ctl, v_none);
    step(LwI, 0, 0, 0); chk("lw_maddr", ctl, f(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      step(LwI, 0, 0, 0); chk("lw_mrd_wait", ctl, f(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    step(LwI, 0, 0, 1); chk("lw_mrd_ready", ctl, f(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(LwI, 0, 0, 0); chk("lw_mwb", ctl, f(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));

    // sw zero-wait: 4 cycles.
    step(SwI, 0, 1, 0); chk("sw_fetch", ctl, v_fetch);
    step(SwI, 0, 0, 0); chk("sw_decode", ctl, v_none);
    step(SwI, 0, 0, 0); chk("sw_maddr", ctl, f(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    step(SwI, 0, 0, 1); chk("sw_mwr", ctl, f(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));

    // beq taken then not taken.
    step(BeqI, 0, 1, 0); chk("beq1_fetch", ctl, v_fetch);
    step(BeqI, 0, 0, 0); chk("beq1_decode", ctl, v_none);
    step(BeqI, 1, 0, 0); chk("beq_taken", ctl, f(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(BeqI, 0, 1, 0); chk("beq0_fetch", ctl, v_fetch);
    step(BeqI, 0, 0, 0); chk("beq0_decode", ctl, v_none);
    step(BeqI, 0, 0, 0); chk("beq_not_taken", ctl, f(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // j / jal / jr.
    for (int i = 0; i < 3; i++) begin
      step(j_ins[i], 0, 1, 0); chk("jmp_fetch", ctl, v_fetch);
      step(j_ins[i], 0, 0, 0); chk("jmp_decode", ctl, v_none);
      step(j_ins[i], 0, 0, 0); chk("jmp_exec", ctl, j_exp[i]);
    end

    // Illegal opcode 0x3F, then sll (unsupported funct).
    step(32'hFC00_0000, 0, 1, 0); chk("ill_op_fetch", ctl, v_fetch);
    step(32'hFC00_0000, 0, 0, 0); chk("ill_op", ctl, f(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(32'h0000_0000, 0, 1, 0); chk("ill_fn_fetch", ctl, v_fetch);
    step(32'h0000_0000, 0, 0, 0); chk("ill_fn", ctl, f(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Fetch watchdog: four waits, abort on the fifth cycle without IRWrite/PCWrite.
    for (int k = 0; k < 4; k++) begin
      step(SwI, 0, 0, 0); chk("to_fetch_wait", ctl, v_wait);
    end
    step(SwI, 0, 0, 0); chk("to_fetch_abort", ctl, f(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Retry: ready arriving in the limit cycle wins.
    for (int k = 0; k < 4; k++) begin
      step(SwI, 0, 0, 0); chk("retry_wait", ctl, v_wait);
    end
    step(SwI, 0, 1, 0); chk("ready_wins", ctl, v_fetch);

    // sw with a hung data memory: MemWrite drops in the abort cycle.
    step(SwI, 0, 0, 0); chk("swto_decode", ctl, v_none);
    step(SwI, 0, 0, 0); chk("swto_maddr", ctl, f(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step(SwI, 0, 0, 0); chk("swto_wait", ctl, f(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    end
    step(SwI, 0, 0, 0); chk("swto_abort", ctl, f(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(SwI, 0, 0, 0); chk("swto_refetch", ctl, v_wait);

    // Reset asserted mid-MWR.
    step(SwI, 0, 1, 0); chk("rst_sw_fetch", ctl, v_fetch);
    step(SwI, 0, 0, 0); chk("rst_sw_decode", ctl, v_none);
    step(SwI, 0, 0, 0); chk("rst_sw_maddr", ctl, f(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    step(SwI, 0, 0, 0); chk("rst_sw_mwr", ctl, f(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_mwr", ctl, v_none);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_back_fetch", ctl, v_wait);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
